// File: rtl/state_mem.sv
// Memory-access stage of the multicycle RV32 CPU. It runs load/store request and
// response handshakes, aligns store lanes, extracts loads and pulses `complete` to write-back.
module state_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_pre,
    input  logic [31:0] PC_input,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] Address,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic        complete,
    output logic [31:0] PC_output,
    output logic [4:0]  RF_waddr,
    output logic [31:0] RF_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        load_q;

    logic [1:0]  in_off;
    logic [3:0]  store_strb;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign in_off = alu_result[1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        store_strb = 4'b0000;
        case (funct3)
            3'b000:  store_strb = 4'b0001 << in_off;
            3'b001:  store_strb = 4'b0011 << {in_off[1], 1'b0};
            3'b010:  store_strb = 4'b1111;
            default: store_strb = 4'b0000;
        endcase
    end

    // Halfword accesses ignore the low address bit; misalignment is not trapped.
    always_comb begin
        load_byte = Read_data[{offset_q, 3'b000} +: 8];
        load_half = Read_data[{offset_q[1], 4'b0000} +: 16];
        load_data = Read_data;
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = Read_data;
        endcase
    end

    // NOTE: state and every datapath register reset asynchronously, so an in-flight
    // request drops the moment rst falls rather than at the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            funct3_q        <= 3'd0;
            offset_q        <= 2'd0;
            load_q          <= 1'b0;
            Address         <= 32'd0;
            MemWrite        <= 1'b0;
            MemRead         <= 1'b0;
            Write_data      <= 32'd0;
            Write_strb      <= 4'd0;
            Read_data_Ready <= 1'b0;
            complete        <= 1'b0;
            PC_output       <= 32'd0;
            RF_waddr        <= 5'd0;
            RF_wdata        <= 32'd0;
            busy            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (complete_pre) begin
                        PC_output  <= PC_input;
                        RF_waddr   <= rd_addr;
                        RF_wdata   <= alu_result;
                        funct3_q   <= funct3;
                        offset_q   <= in_off;
                        load_q     <= is_load;
                        Address    <= {alu_result[31:2], 2'b00};
                        Write_data <= rs2_data << {in_off, 3'b000};
                        Write_strb <= is_store ? store_strb : 4'b0000;
                        busy       <= 1'b1;
                        if (is_load || is_store) begin
                            state    <= REQ;
                            MemRead  <= is_load;
                            MemWrite <= is_store;
                        end else begin
                            state    <= DONE;
                            complete <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (Mem_Req_Ready) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (load_q) begin
                            state           <= RESP;
                            Read_data_Ready <= 1'b1;
                        end else begin
                            state    <= DONE;
                            complete <= 1'b1;
                            RF_waddr <= 5'd0;
                        end
                    end
                end
                RESP: begin
                    if (Read_data_Valid) begin
                        RF_wdata        <= load_data;
                        Read_data_Ready <= 1'b0;
                        state           <= DONE;
                        complete        <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_mem.sv
// Randomised self-checking bench for state_mem: a cycle-count timing model plus
// arithmetic models of store lane alignment and load extraction.
module tb_state_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        complete_pre;
    logic [31:0] PC_input;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic        complete;
    logic [31:0] PC_output;
    logic [4:0]  RF_waddr;
    logic [31:0] RF_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef enum int {K_ALU, K_LOAD, K_STORE} kind_t;

    always #5 clk = ~clk;

    state_mem dut (
        .clk(clk), .rst(rst), .complete_pre(complete_pre), .PC_input(PC_input),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .alu_result(alu_result),
        .rs2_data(rs2_data), .rd_addr(rd_addr), .Address(Address), .MemWrite(MemWrite),
        .MemRead(MemRead), .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ready(Read_data_Ready), .complete(complete), .PC_output(PC_output),
        .RF_waddr(RF_waddr), .RF_wdata(RF_wdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        int a = int'(addr % 4);
        case (f3)
            3'd0:    return 4'(1 << a);
            3'd1:    return 4'(3 << ((a / 2) * 2));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [31:0] addr);
        int a = int'(addr % 4);
        return rs2 << (8 * a);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int a = int'(addr % 4);
        logic [31:0] b = (rdata >> (8 * a)) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // Issues one instruction in the current cycle (cycle 0) and walks to one cycle past DONE.
    task automatic run_txn(input kind_t kind, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
                           input int wr, input int wresp, input logic [31:0] rdata,
                           input bit early);
        bit ld  = (kind == K_LOAD);
        bit st  = (kind == K_STORE);
        bit mem = ld || st;
        int done_cyc = (kind == K_ALU) ? 1 : (st ? 2 + wr : 3 + wr + wresp);
        bit exp_req;
        bit exp_resp;
        complete_pre    = 1'b1;
        PC_input        = pc;
        is_load         = ld;
        is_store        = st;
        funct3          = f3;
        alu_result      = addr;
        rs2_data        = rs2;
        rd_addr         = rd;
        Mem_Req_Ready   = 1'b0;
        Read_data_Valid = 1'b0;
        Read_data       = rdata;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(posedge clk);
            #1;
            complete_pre = 1'b0;
            PC_input     = $urandom;
            alu_result   = $urandom;
            rs2_data     = $urandom;
            rd_addr      = 5'($urandom);
            funct3       = 3'($urandom);
            is_load      = 1'($urandom);
            is_store     = ~is_load;
            exp_req  = mem && (c <= 1 + wr);
            exp_resp = ld && (c >= 2 + wr) && (c <= 2 + wr + wresp);
            check("complete", complete, c == done_cyc);
            check("busy", busy, c <= done_cyc);
            check("mem_read", MemRead, exp_req && ld);
            check("mem_write", MemWrite, exp_req && st);
            check("rd_ready", Read_data_Ready, exp_resp);
            if (exp_req) check("address", Address, {addr[31:2], 2'b00});
            if (exp_req && st) begin
                check("strb", 32'(Write_strb), 32'(model_strb(f3, addr)));
                check("wr_data", Write_data, model_wdata(rs2, addr));
            end
            if (c >= done_cyc) begin
                check("pc_out", PC_output, pc);
                check("rf_waddr", 32'(RF_waddr), st ? 32'd0 : 32'(rd));
                if (!st) check("rf_wdata", RF_wdata, ld ? model_load(f3, addr, rdata) : addr);
            end
            Mem_Req_Ready   = exp_req ? (c == 1 + wr) : 1'($urandom);
            Read_data_Valid = (exp_resp && c == 2 + wr + wresp) || (early && ld && c <= 1 + wr);
        end
    endtask

    // Starts a store (in REQ) or a load (in RESP), pulses rst low for one edge mid-flight.
    task automatic reset_mid(input bit ld, input int cyc);
        complete_pre    = 1'b1;
        is_load         = ld;
        is_store        = !ld;
        funct3          = 3'd2;
        alu_result      = 32'h0000_3004;
        rs2_data        = 32'hDEAD_BEEF;
        rd_addr         = 5'd7;
        PC_input        = 32'h0000_0400;
        Mem_Req_Ready   = 1'b0;
        Read_data_Valid = 1'b0;
        for (int c = 1; c <= cyc; c++) begin
            @(posedge clk);
            #1;
            complete_pre  = 1'b0;
            Mem_Req_Ready = ld && (c == 1);
        end
        if (ld) check("pre_rst_rdy", Read_data_Ready, 1'b1);
        else    check("pre_rst_mw", MemWrite, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_mr", MemRead, 1'b0);
        check("rst_async_mw", MemWrite, 1'b0);
        check("rst_async_rdy", Read_data_Ready, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_cmpl", complete, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            Read_data_Valid = 1'($urandom);
            Mem_Req_Ready   = 1'($urandom);
            check("post_rst_cmpl", complete, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end
        Read_data_Valid = 1'b0;
        Mem_Req_Ready   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lf3 [5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] lexp [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0,
                                  32'h0000_80F0, 32'h80F0_7F01};
        rst = 1'b0; complete_pre = 1'b0; PC_input = '0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; alu_result = '0; rs2_data = '0; rd_addr = '0; Mem_Req_Ready = 1'b0;
        Read_data = '0; Read_data_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_complete", complete, 1'b0);
        check("rst_memread", MemRead, 1'b0);
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_rdready", Read_data_Ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_address", Address, 32'd0);
        check("rst_wdata", Write_data, 32'd0);
        check("rst_strb", 32'(Write_strb), 32'd0);
        check("rst_pc", PC_output, 32'd0);
        check("rst_waddr", 32'(RF_waddr), 32'd0);
        check("rst_rfwdata", RF_wdata, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_txn(K_ALU, 32'h0000_0100, 32'h1234_5678, 32'h0, 5'd5, 3'd0, 0, 0, 32'h0, 1'b0);
        run_txn(K_STORE, 32'h0000_0104, 32'h0000_1003, 32'h0000_00AB, 5'd9, 3'd0, 2, 0, 32'h0, 1'b0);
        check("sb_waddr_zero", 32'(RF_waddr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            run_txn(K_LOAD, 32'h0000_0200 + 32'(4 * i), 32'h0000_2002, 32'h0, 5'd10,
                    lf3[i], i % 2, i % 3, 32'h80F0_7F01, 1'b0);
            check("load_table", RF_wdata, lexp[i]);
        end
        run_txn(K_LOAD, 32'h0000_0300, 32'h0000_2000, 32'h0, 5'd0, 3'd2, 0, 3, 32'h5555_AAAA, 1'b0);
        run_txn(K_LOAD, 32'h0000_0304, 32'h0000_2001, 32'h0, 5'd3, 3'd0, 1, 0, 32'h0000_8000, 1'b1);

        reset_mid(1'b1, 3);
        run_txn(K_ALU, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 5'd1, 3'd0, 0, 0, 32'h0, 1'b0);
        reset_mid(1'b0, 2);
        run_txn(K_ALU, 32'h0000_0504, 32'h0BAD_CAFE, 32'h0, 5'd2, 3'd0, 0, 0, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            kind_t       k     = kind_t'($urandom_range(0, 2));
            logic [2:0]  sf3   = 3'($urandom_range(0, 2));
            logic [2:0]  lsel  = 3'($urandom_range(0, 4));
            logic [2:0]  f3;
            int          wresp = $urandom_range(0, 3);
            bit          early = 1'($urandom) && (wresp == 0);
            if (k == K_STORE)      f3 = sf3;
            else if (k == K_LOAD)  f3 = (lsel < 3) ? lsel : lsel + 3'd1;
            else                   f3 = 3'($urandom);
            run_txn(k, $urandom, $urandom, $urandom, 5'($urandom), f3,
                    $urandom_range(0, 3), wresp, $urandom, early);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
